vs_stream_demux: RTL



---
 rtl/vs_stream_demux_if.sv | 35 +++
 rtl/vs_stream_demux.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/vs_stream_demux_if.sv
// Stream bundle for vs_stream_demux: one producer-side stream carrying a
// channel select, plus N_OUT consumer-side streams packed side by side.
// The master modport is the environment view (producer and consumers).
// The slave modport is the demultiplexer view.
interface vs_stream_demux_if #(
    parameter int WIDTH = 8,
    parameter int N_OUT = 4,
    parameter int SEL_W = $clog2(N_OUT)
);
    // producer side
    logic [SEL_W-1:0]       s_sel;
    logic [WIDTH-1:0]       s_data;
    logic                   s_last;
    logic                   s_valid;
    logic                   s_ready;
    // consumer side, channel i in m_data[i*WIDTH +: WIDTH]
    logic [N_OUT*WIDTH-1:0] m_data;
    logic [N_OUT-1:0]       m_last;
    logic [N_OUT-1:0]       m_valid;
    logic [N_OUT-1:0]       m_ready;

    modport master (
        output s_sel, s_data, s_last, s_valid,
        input  s_ready,
        input  m_data, m_last, m_valid,
        output m_ready
    );

    modport slave (
        input  s_sel, s_data, s_last, s_valid,
        output s_ready,
        output m_data, m_last, m_valid,
        input  m_ready
    );
endinterface

// File: rtl/vs_stream_demux.sv
// 1-to-N streaming demultiplexer with packet-granular routing.
// The route is taken from s_sel on the first beat of a packet and held in
// cur_sel_q until the last beat. Packets addressed past N_OUT-1 are swallowed
// (s_ready forced high) and counted. Each channel has a one-entry output
// register whose data/last read zero whenever its valid is low.
module vs_stream_demux #(
    parameter int WIDTH = 8,
    parameter int N_OUT = 4,
    parameter int SEL_W = $clog2(N_OUT),
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    vs_stream_demux_if.slave  bus,
    output logic              busy,
    output logic              err_drop,
    output logic [CNT_W-1:0]  drop_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_DROP = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   cur_sel_q, cur_sel_d;
    logic [WIDTH-1:0]   data_q [N_OUT];
    logic [WIDTH-1:0]   data_d [N_OUT];
    logic [N_OUT-1:0]   last_q, last_d;
    logic [N_OUT-1:0]   valid_q, valid_d;
    logic               err_drop_q, err_drop_d;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

    logic               first_s;
    logic               sel_ok_s;
    logic               drop_s;
    logic [SEL_W-1:0]   tgt_sel_s;
    logic [N_OUT-1:0]   hit_s;
    logic [N_OUT-1:0]   free_s;
    logic               s_ready_s;
    logic               accept_s;
    logic [N_OUT-1:0]   load_s;
    logic [N_OUT*WIDTH-1:0] m_data_s;

    // Route decode: pick the target channel and decide forward vs discard.
    always_comb begin
        first_s  = (state_q == ST_IDLE);
        sel_ok_s = (32'(bus.s_sel) < 32'(N_OUT));
        if (first_s) begin
            tgt_sel_s = bus.s_sel;
            drop_s    = !sel_ok_s;
        end else begin
            tgt_sel_s = cur_sel_q;
            drop_s    = (state_q == ST_DROP);
        end
        hit_s  = {N_OUT{1'b0}};
        free_s = {N_OUT{1'b0}};
        for (int i = 0; i < N_OUT; i++) begin
            hit_s[i]  = (tgt_sel_s == SEL_W'(i));
            free_s[i] = !valid_q[i] || bus.m_ready[i];
        end
        // Discarded beats are always taken; routed beats wait on their channel.
        if (rst) begin
            s_ready_s = 1'b0;
        end else if (drop_s) begin
            s_ready_s = 1'b1;
        end else begin
            s_ready_s = |(hit_s & free_s);
        end
        accept_s = bus.s_valid && s_ready_s;
        if (accept_s && !drop_s) begin
            load_s = hit_s;
        end else begin
            load_s = {N_OUT{1'b0}};
        end
    end

    // Packet FSM next state, route lock and drop bookkeeping.
    always_comb begin
        state_d    = state_q;
        cur_sel_d  = cur_sel_q;
        err_drop_d = 1'b0;
        drop_cnt_d = drop_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && !bus.s_last) begin
                    state_d = drop_s ? ST_DROP : ST_FWD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FWD, ST_DROP: begin
                if (accept_s && bus.s_last) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (accept_s && first_s) begin
            cur_sel_d  = bus.s_sel;
            err_drop_d = drop_s;
        end else begin
            cur_sel_d  = cur_sel_q;
            err_drop_d = 1'b0;
        end
        // Saturate rather than wrap so a stuck-high count is still meaningful.
        if (err_drop_d && (drop_cnt_q != {CNT_W{1'b1}})) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // Output register next state: load wins over drain, drain zero-fills.
    always_comb begin
        last_d  = last_q;
        valid_d = valid_q;
        for (int i = 0; i < N_OUT; i++) begin
            data_d[i] = data_q[i];
            if (load_s[i]) begin
                data_d[i]  = bus.s_data;
                last_d[i]  = bus.s_last;
                valid_d[i] = 1'b1;
            end else if (valid_q[i] && bus.m_ready[i]) begin
                data_d[i]  = {WIDTH{1'b0}};
                last_d[i]  = 1'b0;
                valid_d[i] = 1'b0;
            end else begin
                data_d[i]  = data_q[i];
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cur_sel_q  <= {SEL_W{1'b0}};
            last_q     <= {N_OUT{1'b0}};
            valid_q    <= {N_OUT{1'b0}};
            err_drop_q <= 1'b0;
            drop_cnt_q <= {CNT_W{1'b0}};
            for (int i = 0; i < N_OUT; i++) begin
                data_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            state_q    <= state_d;
            cur_sel_q  <= cur_sel_d;
            last_q     <= last_d;
            valid_q    <= valid_d;
            err_drop_q <= err_drop_d;
            drop_cnt_q <= drop_cnt_d;
            for (int i = 0; i < N_OUT; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    // Pack per-channel data registers onto the flat output bus.
    always_comb begin
        m_data_s = {(N_OUT*WIDTH){1'b0}};
        for (int i = 0; i < N_OUT; i++) begin
            m_data_s[i*WIDTH +: WIDTH] = data_q[i];
        end
    end

    assign bus.s_ready = s_ready_s;
    assign bus.m_data  = m_data_s;
    assign bus.m_last  = last_q;
    assign bus.m_valid = valid_q;
    assign busy        = (state_q != ST_IDLE);
    assign err_drop    = err_drop_q;
    assign drop_cnt    = drop_cnt_q;

endmodule
